// File: rtl/fpu_div_arb.sv
// fpu_div_arb: round-robin arbiter/sequencer for the shared multi-cycle FPU divider.
// Two requesters, one operation in flight, registered operands and enable to the
// divider, valid/ready response back to the owner.
// Optional watchdog abort: define FDIV_ARB_TIMEOUT_EN.
module fpu_div_arb #(
    parameter int unsigned TAGW = 4,
    parameter int unsigned OPW  = 147
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic            flush_i,
    input  logic [1:0]      req_valid_i,
    output logic [1:0]      req_ready_o,
    input  logic [OPW-1:0]  req0_op_i,
    input  logic [OPW-1:0]  req1_op_i,
    input  logic [TAGW-1:0] req0_tag_i,
    input  logic [TAGW-1:0] req1_tag_i,
    output logic            div_enable_o,
    output logic [OPW-1:0]  div_op_o,
    input  logic            div_ready_i,
    input  logic [31:0]     div_result_i,
    output logic [1:0]      rsp_valid_o,
    input  logic [1:0]      rsp_ready_i,
    output logic [31:0]     rsp_result_o,
    output logic [TAGW-1:0] rsp_tag_o,
    output logic            rsp_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic            ptr_q;
    logic            owner_q;
    logic [TAGW-1:0] tag_q;
    logic            grant;
    logic            accept;
    logic            finish;
    logic [31:0]     fin_result;

    // Grant selection and request handshake (combinational from state, pointer, valids)
    always_comb begin
        grant       = ptr_q;
        req_ready_o = '0;
        if (req_valid_i == 2'b01) begin
            grant = 1'b0;
        end else if (req_valid_i == 2'b10) begin
            grant = 1'b1;
        end
        if (state_q == S_IDLE && !flush_i && resetn_i && (|req_valid_i)) begin
            req_ready_o[grant] = 1'b1;
        end
        accept = |(req_ready_o & req_valid_i);
    end

`ifdef FDIV_ARB_TIMEOUT_EN
    logic [5:0] wdog_q;
    logic       wd_hit;

    // Watchdog fires on the edge where the counter would reach 63
    always_comb begin
        wd_hit     = (state_q == S_RUN) && !div_ready_i && (wdog_q == 6'd62);
        finish     = (state_q == S_RUN) && (div_ready_i || wd_hit);
        fin_result = div_ready_i ? div_result_i : 32'h7FC0_0000;
    end

    // Watchdog counter and abort flag
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wdog_q        <= '0;
            rsp_timeout_o <= 1'b0;
        end else begin
            if (accept) begin
                wdog_q        <= '0;
                rsp_timeout_o <= 1'b0;
            end else if (state_q == S_RUN) begin
                wdog_q <= wdog_q + 6'd1;
                if (!flush_i && finish) begin
                    rsp_timeout_o <= wd_hit;
                end
            end
        end
    end
`else
    // Completion comes only from the divider
    always_comb begin
        finish     = (state_q == S_RUN) && div_ready_i;
        fin_result = div_result_i;
    end

    assign rsp_timeout_o = 1'b0;
`endif

    // Next-state logic; flush outranks completion and response handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_RUN;
            S_RUN: begin
                if (flush_i)     state_d = S_IDLE;
                else if (finish) state_d = S_RESP;
            end
            S_RESP: begin
                if (flush_i)                   state_d = S_IDLE;
                else if (rsp_ready_i[owner_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response valid is one-hot to the owner while in RESP
    always_comb begin
        rsp_valid_o = '0;
        if (state_q == S_RESP) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
    end

    // State, pointer, operand/enable and result registers
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            tag_q        <= '0;
            div_enable_o <= 1'b0;
            div_op_o     <= '0;
            rsp_result_o <= '0;
            rsp_tag_o    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ptr_q        <= ~grant;
                owner_q      <= grant;
                tag_q        <= grant ? req1_tag_i : req0_tag_i;
                div_op_o     <= grant ? req1_op_i : req0_op_i;
                div_enable_o <= 1'b1;
            end else if (state_q == S_RUN && (flush_i || finish)) begin
                div_enable_o <= 1'b0;
            end
            if (state_q == S_RUN && !flush_i && finish) begin
                rsp_result_o <= fin_result;
                rsp_tag_o    <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_fpu_div_arb.sv
// Directed self-checking bench for fpu_div_arb (default parameters).
// Define FDIV_ARB_TIMEOUT_EN to also exercise the watchdog abort.
module tb_fpu_div_arb;

    localparam int unsigned TAGW = 4;
    localparam int unsigned OPW  = 147;

    logic            clk_i = 1'b0;
    logic            resetn_i;
    logic            flush_i;
    logic [1:0]      req_valid_i;
    logic [1:0]      req_ready_o;
    logic [OPW-1:0]  req0_op_i, req1_op_i;
    logic [TAGW-1:0] req0_tag_i, req1_tag_i;
    logic            div_enable_o;
    logic [OPW-1:0]  div_op_o;
    logic            div_ready_i;
    logic [31:0]     div_result_i;
    logic [1:0]      rsp_valid_o;
    logic [1:0]      rsp_ready_i;
    logic [31:0]     rsp_result_o;
    logic [TAGW-1:0] rsp_tag_o;
    logic            rsp_timeout_o;

    int errors = 0;
    int checks = 0;

    fpu_div_arb #(.TAGW(TAGW), .OPW(OPW)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req0_op_i(req0_op_i), .req1_op_i(req1_op_i),
        .req0_tag_i(req0_tag_i), .req1_tag_i(req1_tag_i),
        .div_enable_o(div_enable_o), .div_op_o(div_op_o),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
        .rsp_timeout_o(rsp_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Single comparison point: count and report a mismatch
    task automatic check(input string tag, input logic [OPW-1:0] act, input logic [OPW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock, settle 1 time unit past the edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [OPW-1:0] mk_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        return {a, 40'h0, b, 40'h0, rm};
    endfunction

    task automatic do_reset();
        resetn_i = 1'b0;
        #3;
        resetn_i = 1'b1;
        tick();
    endtask

    // One full transaction: present requests, check grant, run the divider
    // for lat cycles, check response, then consume it.
    task automatic serve(input string nm, input logic [1:0] vld, input logic [1:0] exp_gnt,
                         input logic [OPW-1:0] exp_op, input logic [TAGW-1:0] exp_tag,
                         input logic [31:0] res, input int lat);
        logic en_ok;
        req_valid_i = vld;
        #1;
        check({nm, ".grant"}, OPW'(req_ready_o), OPW'(exp_gnt));
        tick();
        req_valid_i = 2'b00;
        check({nm, ".op"}, div_op_o, exp_op);
        en_ok = 1'b1;
        for (int i = 0; i < lat; i++) begin
            if (!div_enable_o || div_op_o !== exp_op || rsp_valid_o != 2'b00) en_ok = 1'b0;
            tick();
        end
        check({nm, ".run_hold"}, OPW'(en_ok), OPW'(1'b1));
        div_ready_i  = 1'b1;
        div_result_i = res;
        tick();
        div_ready_i  = 1'b0;
        div_result_i = 32'hDEAD_BEEF;
        check({nm, ".en_drop"}, OPW'(div_enable_o), OPW'(1'b0));
        check({nm, ".rsp_valid"}, OPW'(rsp_valid_o), OPW'(exp_gnt));
        check({nm, ".result"}, OPW'(rsp_result_o), OPW'(res));
        check({nm, ".tag"}, OPW'(rsp_tag_o), OPW'(exp_tag));
        check({nm, ".timeout"}, OPW'(rsp_timeout_o), OPW'(1'b0));
        // non-owner ready must be ignored
        rsp_ready_i = ~exp_gnt;
        tick();
        check({nm, ".nonowner"}, OPW'(rsp_valid_o), OPW'(exp_gnt));
        rsp_ready_i = exp_gnt;
        tick();
        rsp_ready_i = 2'b00;
        check({nm, ".rsp_done"}, OPW'(rsp_valid_o), OPW'(2'b00));
    endtask

    logic [OPW-1:0] op_a, op_b;
    logic           stable;
    int             cyc;

    initial begin
        op_a = mk_op(32'h40C0_0000, 32'h4000_0000, 3'd0); // 6.0 / 2.0
        op_b = mk_op(32'h4120_0000, 32'h4080_0000, 3'd1); // 10.0 / 4.0
        resetn_i     = 1'b0;
        flush_i      = 1'b0;
        req_valid_i  = 2'b11;
        req0_op_i    = op_a;
        req1_op_i    = op_b;
        req0_tag_i   = 4'd3;
        req1_tag_i   = 4'd2;
        div_ready_i  = 1'b0;
        div_result_i = '0;
        rsp_ready_i  = 2'b00;

        // Reset state
        tick();
        check("rst.ready", OPW'(req_ready_o), OPW'(2'b00));
        check("rst.en", OPW'(div_enable_o), OPW'(1'b0));
        check("rst.op", div_op_o, '0);
        check("rst.rsp_valid", OPW'(rsp_valid_o), OPW'(2'b00));
        check("rst.result", OPW'(rsp_result_o), OPW'(32'h0));
        check("rst.tag", OPW'(rsp_tag_o), OPW'(4'h0));
        check("rst.timeout", OPW'(rsp_timeout_o), OPW'(1'b0));
        req_valid_i = 2'b00;
        do_reset();

        // Single request: 6.0/2.0 = 3.0 from requester 0, tag 3
        serve("single", 2'b01, 2'b01, op_a, 4'd3, 32'h4040_0000, 6);

        // Round-robin from reset with tags 1 and 2
        do_reset();
        req0_tag_i = 4'd1;
        serve("rr0", 2'b11, 2'b01, op_a, 4'd1, 32'h4040_0000, 4);
        serve("rr1", 2'b11, 2'b10, op_b, 4'd2, 32'h4020_0000, 3);
        serve("rr2", 2'b11, 2'b01, op_a, 4'd1, 32'h4040_0000, 2);

        // Flush during RUN, 10 cycles after accept
        req1_tag_i  = 4'd5;
        req_valid_i = 2'b10;
        #1;
        check("flush.grant", OPW'(req_ready_o), OPW'(2'b10));
        tick();
        req_valid_i = 2'b00;
        repeat (10) tick();
        flush_i = 1'b1;
        div_ready_i = 1'b1;  // flush wins over completion on the same edge
        div_result_i = 32'h1234_5678;
        tick();
        flush_i = 1'b0;
        div_ready_i = 1'b0;
        check("flush.en", OPW'(div_enable_o), OPW'(1'b0));
        check("flush.rsp", OPW'(rsp_valid_o), OPW'(2'b00));
        div_ready_i = 1'b1;  // late completion in IDLE
        tick();
        div_ready_i = 1'b0;
        check("flush.late_rsp", OPW'(rsp_valid_o), OPW'(2'b00));
        check("flush.late_en", OPW'(div_enable_o), OPW'(1'b0));
        flush_i = 1'b1;
        req_valid_i = 2'b01;
        #1;
        check("flush.idle_ready", OPW'(req_ready_o), OPW'(2'b00));
        flush_i = 1'b0;
        req0_tag_i = 4'd9;
        serve("post_flush", 2'b01, 2'b01, op_a, 4'd9, 32'h4040_0000, 5);

        // Response backpressure, then reset mid-RUN
        req0_tag_i  = 4'd7;
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        repeat (3) tick();
        div_ready_i  = 1'b1;
        div_result_i = 32'h3F80_0000;
        tick();
        div_ready_i  = 1'b0;
        req_valid_i  = 2'b10;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid_o != 2'b01 || rsp_result_o != 32'h3F80_0000 ||
                rsp_tag_o != 4'd7 || req_ready_o != 2'b00) stable = 1'b0;
            tick();
        end
        check("bp.stable", OPW'(stable), OPW'(1'b1));
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        check("bp.next_ready", OPW'(req_ready_o), OPW'(2'b10));
        tick();
        req_valid_i = 2'b00;
        check("bp.run_en", OPW'(div_enable_o), OPW'(1'b1));
        repeat (3) tick();
        #2;
        resetn_i = 1'b0;   // asynchronous, between clock edges
        #1;
        check("arst.en", OPW'(div_enable_o), OPW'(1'b0));
        check("arst.op", div_op_o, '0);
        check("arst.rsp", OPW'(rsp_valid_o), OPW'(2'b00));
        check("arst.result", OPW'(rsp_result_o), OPW'(32'h0));
        req_valid_i = 2'b11;
        #1;
        check("arst.ready", OPW'(req_ready_o), OPW'(2'b00));
        req_valid_i = 2'b00;
        resetn_i = 1'b1;
        tick();

`ifdef FDIV_ARB_TIMEOUT_EN
        // Watchdog: no completion ever arrives
        req0_tag_i  = 4'd4;
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        cyc = 0;
        while (rsp_valid_o == 2'b00 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("wd.cycles", OPW'(cyc), OPW'(63));
        check("wd.result", OPW'(rsp_result_o), OPW'(32'h7FC0_0000));
        check("wd.flag", OPW'(rsp_timeout_o), OPW'(1'b1));
        check("wd.tag", OPW'(rsp_tag_o), OPW'(4'd4));
        rsp_ready_i = 2'b01;
        tick();
        rsp_ready_i = 2'b00;
        req_valid_i = 2'b01;
        tick();
        req_valid_i = 2'b00;
        check("wd.clear", OPW'(rsp_timeout_o), OPW'(1'b0));
`else
        cyc = 0;
        check("no_wd.flag", OPW'(rsp_timeout_o), OPW'(1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_div_arb.md
# fpu_div_arb

Arbiter and sequencer for the shared multi-cycle FPU divider. It accepts divide requests from two requester ports, grants them round-robin, and holds registered, stable operands and `div_enable_o` on the divider for the whole operation. It drops the enable on completion so the divider counter re-arms, and returns the result to the owning requester through a valid/ready response port. It sits between the FPU issue logic and the divider datapath.

## Interface
- `TAGW`, default 4: requester tag width, returned unchanged with the response.
- `OPW`, default 147: operand bundle width, `{rs1[31:0], rs1Exp[9:0], rs1Sig[23:0], rs1Class[5:0], rs2[31:0], rs2Exp[9:0], rs2Sig[23:0], rs2Class[5:0], rm[2:0]}`.

Ports:
- `clk_i`  in  1  single clock; all state updates on posedge.
- `resetn_i`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  abort the in-flight operation and discard its result.
- `req_valid_i`  in  2  request valid, bit n = requester n.
- `req_ready_o`  out  2  request accepted on posedge when valid&ready.
- `req0_op_i`, `req1_op_i`  in  OPW  operand bundles.
- `req0_tag_i`, `req1_tag_i`  in  TAGW  request tags.
- `div_enable_o`  out  1  divider enable; registered.
- `div_op_o`  out  OPW  registered operand bundle to the divider.
- `div_ready_i`  in  1  divider completion pulse, high across exactly one posedge.
- `div_result_i`  in  32  divider result, valid while `div_ready_i` is high.
- `rsp_valid_o`  out  2  response valid, one-hot to the owner.
- `rsp_ready_i`  in  2  response consumed.
- `rsp_result_o`  out  32  captured result.
- `rsp_tag_o`  out  TAGW  tag of the request that produced the result.
- `rsp_timeout_o`  out  1  the response is a watchdog abort.

## Operation
FSM states are IDLE, RUN and RESP.

- **IDLE**
  - `req_ready_o[g]` = 1 only for the granted requester g, and only when `flush_i` = 0. It is combinational from state, pointer and `req_valid_i`.
  - Grant: if only one requester is valid, it is granted. If both are valid, grant `ptr`.
  - On accept:
    - latch op, tag and owner into registers;
    - set `ptr` to the requester other than the one granted;
    - go to RUN.
- **RUN**
  - `div_enable_o` = 1 and `div_op_o` holds constant.
  - On a posedge with `div_ready_i` = 1: capture `div_result_i`, go to RESP. `div_enable_o` is 0 from that edge on.
- **RESP**
  - `div_enable_o` = 0.
  - `rsp_valid_o[owner]` = 1, with `rsp_result_o` and `rsp_tag_o` stable.
  - On `rsp_ready_i[owner]`: go to IDLE. `rsp_ready_i` of the non-owner is ignored.
- **Flush:** in RUN or RESP, `flush_i` forces IDLE at the next posedge, with `div_enable_o` = 0 and no response. Flush has priority over `div_ready_i` and `rsp_ready_i` on the same edge.
- `div_ready_i` is ignored in IDLE and RESP.
- Any number of requests per requester may queue externally; the block holds exactly one operation.

## Timing
- Reset values (asynchronous):
  - state = IDLE, `ptr` = 0;
  - `div_enable_o` = 0, `div_op_o` = 0;
  - `rsp_valid_o` = 0, `rsp_result_o` = 0, `rsp_tag_o` = 0, `rsp_timeout_o` = 0;
  - `req_ready_o` = 0 while `resetn_i` is low.
- Reset mid-operation drops the enable immediately. The divider counter re-arms on its next posedge with the enable low.
- Accept at posedge N → `div_enable_o` high from N, and the divider loads at posedge N+1.
- `div_ready_i` at posedge M → `rsp_valid_o` high from M. Total latency is the divider latency plus 1.
- There is at least one cycle with enable low between operations (RESP→IDLE→RUN). This prevents the divider from auto-restarting after it reaches count 0.
- Response accepted at posedge K → the earliest next accept is posedge K+1.

## Configuration
- `FDIV_ARB_TIMEOUT_EN` defined:
  - a 6-bit watchdog clears on RUN entry and increments each cycle in RUN;
  - if it reaches 63 without `div_ready_i`, the block captures result 0x7FC00000, sets `rsp_timeout_o` = 1 and goes to RESP;
  - `rsp_timeout_o` clears on the next accept.
- `FDIV_ARB_TIMEOUT_EN` undefined: no watchdog logic, `rsp_timeout_o` is tied 0, and RUN waits indefinitely.

## Test plan
- **Single request, correct sequencing.** Requester 0 sends 6.0/2.0 (rs1 = 0x40C00000, rs2 = 0x40000000, rm = 0) with tag 3. Required:
  - `rsp_valid_o` = 01, `rsp_result_o` = 0x40400000, `rsp_tag_o` = 3;
  - `div_enable_o` high continuously from accept to the `div_ready_i` edge, then low.
- **Simultaneous requests, round-robin.** Both requesters valid after reset, with tags 1 and 2. Required:
  - requester 0 is served first, then requester 1, then requester 0 again on the next tie;
  - each response goes only to its owner with the correct tag.
- **Flush during RUN.** Assert `flush_i` 10 cycles after accept. Required:
  - `div_enable_o` is 0 the next cycle;
  - no `rsp_valid_o`;
  - a late `div_ready_i` is ignored;
  - the next request completes correctly.
- **Response backpressure and reset.** Hold `rsp_ready_i` = 0 for 20 cycles. Required:
  - result and tag hold stable;
  - `req_ready_o` stays 00 while the other requester is valid;
  - an asynchronous reset mid-RUN clears all outputs without waiting for a clock edge.
- **Timeout.** With `FDIV_ARB_TIMEOUT_EN` defined, never assert `div_ready_i`. Required: 63 cycles after RUN entry, response 0x7FC00000 with `rsp_timeout_o` = 1.
